// File: rtl/reg_file_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : reg_file_pkg
// Purpose : Shared sizes and types for the 8 x 8-bit general-purpose
//           register file of the processor datapath.
// Contents: DATA_W, ADDR_W, NREGS localparams; data_t and addr_t typedefs.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : reg_file_read_port
// Purpose : Combinational NREGS:1 DATA_W-bit read mux for one register-file
//           read port.
// Ports   : regs  in   NREGS x DATA_W  flattened register contents
//           addr  in   ADDR_W          register select
//           data  out  DATA_W          contents of regs[addr]
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  data_t [NREGS-1:0] regs,
  input  addr_t             addr,
  output data_t             data
);

  // Every address is implemented, so the index is always in range.
  assign data = regs[addr];

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : reg_file
// Purpose : 8 x 8-bit general-purpose register file. Two combinational read
//           ports feed the ALU operands; one synchronous write port is driven
//           by writeback. No write-through bypass: a same-cycle read of the
//           written address returns the old value until the clock edge.
// Ports   : clk       in   1       clock, rising edge
//           rst_n     in   1       asynchronous active-low reset (clears all)
//           regwrite  in   1       write enable
//           ra1, ra2  in   ADDR_W  read addresses
//           wa        in   ADDR_W  write address
//           wd        in   DATA_W  write data
//           rd1, rd2  out  DATA_W  read data (combinational)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  data_t [NREGS-1:0] r_regs;
  logic  [NREGS-1:0] w_we;

  // One-hot write-enable decode of wa, gated by regwrite.
  always_comb begin
    w_we = '0;
    if (regwrite) begin
      w_we[wa] = 1'b1;
    end
  end

  // Reset clears every register asynchronously, so an in-flight write is
  // simply dropped when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= wd;
        end
      end
    end
  end

  reg_file_read_port u_read_port1 (
    .regs (r_regs),
    .addr (ra1),
    .data (rd1)
  );

  reg_file_read_port u_read_port2 (
    .regs (r_regs),
    .addr (ra2),
    .data (rd2)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_reg_file
// Purpose : Self-checking bench for reg_file. A plain array holds the
//           expected register contents; directed cases plus random traffic
//           are compared against it.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_reg_file;

  logic       clk;
  logic       rst_n;
  logic       regwrite;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic [2:0] wa;
  logic [7:0] wd;
  logic [7:0] rd1;
  logic [7:0] rd2;

  logic [7:0] model [8];

  int n_checks;
  int n_pass;

  reg_file u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .regwrite (regwrite),
    .ra1      (ra1),
    .ra2      (ra2),
    .wa       (wa),
    .wd       (wd),
    .rd1      (rd1),
    .rd2      (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge; the model takes the write the DUT should take.
  task automatic tick();
    @(posedge clk);
    if (rst_n && regwrite) model[wa] = wd;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  // Sweep ra1 upward and ra2 downward, comparing every register.
  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i);
      ra2 = 3'(7 - i);
      #1;
      check({tag, "_rd1"}, rd1, model[i]);
      check({tag, "_rd2"}, rd2, model[7 - i]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    regwrite = 1'b0;
    ra1      = 3'd5;
    ra2      = 3'd2;
    wa       = 3'd0;
    wd       = 8'h00;
    clear_model();

    // Reset: everything reads zero during and after reset.
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("post_reset");

    // Write 0 then 67 to register 1.
    ra1 = 3'd1; ra2 = 3'd1;
    regwrite = 1'b1; wa = 3'd1; wd = 8'd0;
    tick();
    check("w0_rd1", rd1, 8'd0);
    check("w0_rd2", rd2, 8'd0);
    wd = 8'd67;
    tick();
    check("w67_rd1", rd1, 8'd67);
    check("w67_rd2", rd2, 8'd67);

    // Write disabled: register 1 keeps 67.
    regwrite = 1'b0; wd = 8'hFF;
    repeat (3) tick();
    check("wdis_rd1", rd1, 8'd67);
    check("wdis_rd2", rd2, 8'd67);

    // Same-cycle read/write: old value before the edge, new after.
    ra1 = 3'd2; ra2 = 3'd1;
    regwrite = 1'b1; wa = 3'd2; wd = 8'hA5;
    #1;
    check("rw_before", rd1, 8'h00);
    tick();
    check("rw_after", rd1, 8'hA5);
    check("rw_other", rd2, 8'd67);

    // Fill all registers with 0x10+i.
    for (int i = 0; i < 8; i++) begin
      regwrite = 1'b1; wa = 3'(i); wd = 8'(8'h10 + i);
      tick();
    end
    regwrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i);
      ra2 = 3'(7 - i);
      #1;
      check("fill_rd1", rd1, 8'(8'h10 + i));
      check("fill_rd2", rd2, 8'(8'h17 - i));
    end

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      regwrite = 1'($urandom_range(0, 1));
      wa       = 3'($urandom_range(0, 7));
      wd       = 8'($urandom);
      ra1      = 3'($urandom_range(0, 7));
      ra2      = ($urandom_range(0, 3) == 0) ? ra1 : 3'($urandom_range(0, 7));
      #1;
      check("rand_pre_rd1", rd1, model[ra1]);
      check("rand_pre_rd2", rd2, model[ra2]);
      tick();
      check("rand_post_rd1", rd1, model[ra1]);
      check("rand_post_rd2", rd2, model[ra2]);
    end

    // Make sure every register holds a nonzero value before the async reset.
    for (int i = 0; i < 8; i++) begin
      regwrite = 1'b1; wa = 3'(i); wd = 8'(8'hC0 + i);
      tick();
    end
    check_all("pre_async");

    // Async reset between edges while a write is pending.
    ra1 = 3'd3; ra2 = 3'd5;
    regwrite = 1'b1; wa = 3'd3; wd = 8'h5A;
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("async_rd1", rd1, 8'h00);
    check("async_rd2", rd2, 8'h00);
    check_all("async_hold");
    regwrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("async_release");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
